// File: rtl/sdrd_sector_window.sv
// sdrd_sector_window: fetch one SD sector over SPI and capture a 64-byte aligned window of it for the FAT32 controller
module sdrd_sector_window #(
    parameter int TMO_W = 20
) (
    input  logic         CLK,
    input  logic         RST_X,
    input  logic         SPI_INIT,
    input  logic         REQ,
    input  logic [31:0]  REQ_ADR,
    input  logic [1:0]   REQ_TYPE,
    output logic         SPI_RD_REQ,
    output logic [22:0]  SPI_SECTOR,
    input  logic         SPI_RD_ACK,
    input  logic [7:0]   SPI_BYTE,
    input  logic         SPI_BYTE_VALID,
    output logic [511:0] FATIN_PRM,
    output logic         FATIN_VALID,
    output logic [1:0]   FATIN_TYPE,
    output logic         BUSY,
    output logic         ERR
);
    typedef enum logic [1:0] {IDLE, ISSUE, RECV, DONE} state_t;
    localparam logic [TMO_W-1:0] TMO_ONE = 1;
    localparam logic [TMO_W-1:0] TMO_END = {{(TMO_W-1){1'b1}}, 1'b0};
    state_t state, state_nx;
    logic [2:0] win;
    logic [9:0] cnt;
    logic [TMO_W-1:0] tmo;
    logic start, active, byte_ok, tmo_clr, tmo_hit;
    logic unused_adr;
    assign unused_adr = ^REQ_ADR[5:0];
    always_comb begin
        start    = state == IDLE && REQ && !SPI_INIT;
        active   = state == ISSUE || state == RECV;
        byte_ok  = state == RECV && SPI_BYTE_VALID && !SPI_INIT;
        tmo_clr  = byte_ok || (state == ISSUE && SPI_RD_ACK);
        // fire on the edge where the idle count would reach all-ones
        tmo_hit  = active && !tmo_clr && !SPI_INIT && tmo == TMO_END;
        state_nx = SPI_INIT || tmo_hit ? IDLE :
                   state == IDLE  ? (start ? ISSUE : IDLE) :
                   state == ISSUE ? (SPI_RD_ACK ? RECV : ISSUE) :
                   state == RECV  ? (byte_ok && cnt == 10'd511 ? DONE : RECV) :
                   IDLE;
    end
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state       <= IDLE;
            win         <= '0;
            cnt         <= '0;
            tmo         <= '0;
            SPI_RD_REQ  <= 1'b0;
            SPI_SECTOR  <= '0;
            FATIN_PRM   <= '0;
            FATIN_VALID <= 1'b0;
            FATIN_TYPE  <= '0;
            BUSY        <= 1'b0;
            ERR         <= 1'b0;
        end else begin
            state       <= state_nx;
            SPI_RD_REQ  <= state_nx == ISSUE;
            BUSY        <= state_nx != IDLE;
            FATIN_VALID <= state_nx == DONE;
            ERR         <= tmo_hit;
            if (start) begin
                SPI_SECTOR <= REQ_ADR[31:9];
                win        <= REQ_ADR[8:6];
                FATIN_TYPE <= REQ_TYPE;
            end
            cnt <= start ? '0 : byte_ok ? cnt + 10'd1 : cnt;
            tmo <= start || tmo_clr ? '0 : active ? tmo + TMO_ONE : tmo;
            if (byte_ok && cnt[8:6] == win)
                FATIN_PRM[{cnt[5:0], 3'b000} +: 8] <= SPI_BYTE;
        end
    end
endmodule

// File: tb/tb_sdrd_sector_window.sv
// tb_sdrd_sector_window: directed bench with a response scoreboard for sdrd_sector_window
module tb_sdrd_sector_window;
    logic CLK = 0, RST_X = 0, SPI_INIT = 0, REQ = 0, SPI_RD_ACK = 0, SPI_BYTE_VALID = 0;
    logic [31:0] REQ_ADR = 0;
    logic [1:0] REQ_TYPE = 0;
    logic [7:0] SPI_BYTE = 0;
    logic SPI_RD_REQ, FATIN_VALID, BUSY, ERR;
    logic [22:0] SPI_SECTOR;
    logic [511:0] FATIN_PRM;
    logic [1:0] FATIN_TYPE;
    typedef struct {logic is_err; logic [511:0] prm; logic [1:0] typ;} exp_t;
    exp_t sb[$];
    int checks = 0, errors = 0;
    always #5 CLK = ~CLK;
    sdrd_sector_window #(.TMO_W(4)) dut (
        .CLK(CLK), .RST_X(RST_X), .SPI_INIT(SPI_INIT), .REQ(REQ), .REQ_ADR(REQ_ADR),
        .REQ_TYPE(REQ_TYPE), .SPI_RD_REQ(SPI_RD_REQ), .SPI_SECTOR(SPI_SECTOR),
        .SPI_RD_ACK(SPI_RD_ACK), .SPI_BYTE(SPI_BYTE), .SPI_BYTE_VALID(SPI_BYTE_VALID),
        .FATIN_PRM(FATIN_PRM), .FATIN_VALID(FATIN_VALID), .FATIN_TYPE(FATIN_TYPE),
        .BUSY(BUSY), .ERR(ERR)
    );
    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    // sector byte k carries k[7:0] ^ seed
    function automatic logic [511:0] exp_prm(input logic [2:0] w, input logic [7:0] seed);
        logic [511:0] r;
        logic [9:0] k;
        for (int i = 0; i < 64; i++) begin
            k = {w, 6'(i)};
            r[8*i +: 8] = k[7:0] ^ seed;
        end
        return r;
    endfunction
    always @(negedge CLK) begin : monitor
        exp_t e;
        if (RST_X && (FATIN_VALID || ERR)) begin
            if (sb.size() == 0)
                chk("unexpected_output", 512'({FATIN_VALID, ERR}), 512'd0);
            else begin
                e = sb.pop_front();
                chk("resp_kind", 512'({FATIN_VALID, ERR}), e.is_err ? 512'd1 : 512'd2);
                if (!e.is_err) begin
                    chk("fatin_prm", FATIN_PRM, e.prm);
                    chk("fatin_type", 512'(FATIN_TYPE), 512'(e.typ));
                end
            end
        end
    end
    task automatic do_req(input logic [31:0] adr, input logic [1:0] typ, input logic [22:0] sector);
        REQ = 1; REQ_ADR = adr; REQ_TYPE = typ;
        @(negedge CLK);
        REQ = 0;
        chk("busy_after_req", 512'(BUSY), 512'd1);
        chk("rd_req_after_req", 512'(SPI_RD_REQ), 512'd1);
        chk("spi_sector", 512'(SPI_SECTOR), 512'(sector));
    endtask
    task automatic do_ack(input int dly);
        repeat (dly) begin
            @(negedge CLK);
            chk("rd_req_held", 512'(SPI_RD_REQ), 512'd1);
        end
        SPI_RD_ACK = 1;
        @(negedge CLK);
        SPI_RD_ACK = 0;
        chk("rd_req_drop", 512'(SPI_RD_REQ), 512'd0);
    endtask
    task automatic send_bytes(input int first, input int last, input int gap, input logic [7:0] seed);
        for (int k = first; k <= last; k++) begin
            SPI_BYTE_VALID = 1; SPI_BYTE = 8'(k) ^ seed;
            @(negedge CLK);
            SPI_BYTE_VALID = 0;
            if (k != last) repeat (gap > 0 ? $urandom_range(gap, 0) : 0) @(negedge CLK);
        end
    endtask
    task automatic push_ok(input logic [2:0] w, input logic [1:0] typ, input logic [7:0] seed);
        exp_t e;
        e.is_err = 0; e.prm = exp_prm(w, seed); e.typ = typ;
        sb.push_back(e);
    endtask
    task automatic finish_xfer();
        chk("valid_latency", 512'(FATIN_VALID), 512'd1);
        chk("busy_in_done", 512'(BUSY), 512'd1);
        @(negedge CLK);
        chk("busy_cleared", 512'(BUSY), 512'd0);
    endtask
    task automatic xfer(input logic [31:0] adr, input logic [1:0] typ, input logic [22:0] sector,
                        input int ackdly, input int gap, input logic [7:0] seed);
        push_ok(adr[8:6], typ, seed);
        do_req(adr, typ, sector);
        do_ack(ackdly);
        send_bytes(0, 511, gap, seed);
        finish_xfer();
    endtask
    initial begin
        exp_t te;
        int n;
        repeat (3) @(negedge CLK);
        chk("rst_rd_req", 512'(SPI_RD_REQ), 512'd0);
        chk("rst_sector", 512'(SPI_SECTOR), 512'd0);
        chk("rst_prm", FATIN_PRM, 512'd0);
        chk("rst_valid_type", 512'({FATIN_VALID, FATIN_TYPE}), 512'd0);
        chk("rst_busy_err", 512'({BUSY, ERR}), 512'd0);
        RST_X = 1;
        @(negedge CLK);
        xfer(32'h0000_0000, 2'd0, 23'd0, 2, 0, 8'h00);
        chk("w0_first", 512'(FATIN_PRM[7:0]), 512'(8'h00));
        chk("w0_last", 512'(FATIN_PRM[511:504]), 512'(8'h3F));
        xfer(32'h0000_05C0, 2'd2, 23'd2, 1, 0, 8'h00);
        chk("w7_first", 512'(FATIN_PRM[7:0]), 512'(8'hC0));
        chk("w7_last", 512'(FATIN_PRM[511:504]), 512'(8'hFF));
        chk("w7_type", 512'(FATIN_TYPE), 512'd2);
        xfer(32'h0000_0280, 2'd1, 23'd1, 7, 5, 8'h00);
        chk("gap_first", 512'(FATIN_PRM[7:0]), 512'(8'h80));
        chk("gap_last", 512'(FATIN_PRM[511:504]), 512'(8'hBF));
        // abort after byte 300; window 7 not yet reached so the window-2 data must survive
        do_req(32'h0000_1FC0, 2'd3, 23'h0F);
        do_ack(1);
        send_bytes(0, 300, 0, 8'h00);
        SPI_INIT = 1;
        @(negedge CLK);
        chk("abort_busy", 512'(BUSY), 512'd0);
        chk("abort_rd_req", 512'(SPI_RD_REQ), 512'd0);
        SPI_INIT = 0;
        repeat (20) @(negedge CLK);
        chk("abort_prm_first", 512'(FATIN_PRM[7:0]), 512'(8'h80));
        chk("abort_prm_last", 512'(FATIN_PRM[511:504]), 512'(8'hBF));
        xfer(32'h0000_1FC0, 2'd3, 23'h0F, 0, 1, 8'h5A);
        chk("post_abort_first", 512'(FATIN_PRM[7:0]), 512'(8'h9A));
        chk("post_abort_last", 512'(FATIN_PRM[511:504]), 512'(8'hA5));
        // timeout: bytes stop after byte 10
        te.is_err = 1; te.prm = '0; te.typ = 0;
        sb.push_back(te);
        do_req(32'h0000_0400, 2'd1, 23'd2);
        do_ack(1);
        send_bytes(0, 10, 0, 8'hC3);
        n = 0;
        while (!ERR && n < 40) begin
            @(negedge CLK);
            n++;
        end
        chk("err_delay", 512'(n), 512'd15);
        @(negedge CLK);
        chk("err_pulse_end", 512'(ERR), 512'd0);
        chk("err_busy", 512'(BUSY), 512'd0);
        // busy guard: second REQ mid-RECV is ignored
        push_ok(3'd1, 2'd1, 8'h33);
        do_req(32'h0000_0A40, 2'd1, 23'd5);
        do_ack(0);
        send_bytes(0, 99, 0, 8'h33);
        REQ = 1; REQ_ADR = 32'h0000_1234; REQ_TYPE = 2'd3;
        @(negedge CLK);
        REQ = 0;
        chk("guard_sector", 512'(SPI_SECTOR), 512'd5);
        send_bytes(100, 511, 0, 8'h33);
        finish_xfer();
        repeat (5) @(negedge CLK);
        chk("guard_sector_after", 512'(SPI_SECTOR), 512'd5);
        chk("guard_first", 512'(FATIN_PRM[7:0]), 512'(8'h73));
        chk("guard_last", 512'(FATIN_PRM[511:504]), 512'(8'h4C));
        // asynchronous reset mid-RECV
        do_req(32'h0000_0280, 2'd2, 23'd1);
        do_ack(0);
        send_bytes(0, 200, 0, 8'h11);
        chk("pre_rst_busy", 512'(BUSY), 512'd1);
        #2 RST_X = 0;
        #1;
        chk("arst_rd_req_sector", 512'({SPI_RD_REQ, SPI_SECTOR}), 512'd0);
        chk("arst_prm", FATIN_PRM, 512'd0);
        chk("arst_misc", 512'({FATIN_VALID, FATIN_TYPE, BUSY, ERR}), 512'd0);
        @(negedge CLK);
        RST_X = 1;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        chk("sb_drained", 512'(sb.size()), 512'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
